// File: rtl/greycode_pkg.sv
// Shared types and helpers for the Gray-code receive tracker.
package greycode_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic {IDLE, TRACK} state_e;

  // Prefix XOR from the MSB; zero-extend narrower Gray words before calling.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/greycode_decode.sv
// Combinational Gray-to-binary converter, inverse of binary_to_greycode.
module greycode_decode #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  always_comb begin
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
  end

endmodule

// File: rtl/greycode_to_binary_tracker.sv
// Two-stage Gray decoder that classifies each sample against the previous one
// as a single step up/down or an illegal multi-step jump.
module greycode_to_binary_tracker
  import greycode_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] G,
  input  logic             in_valid,
  output logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             skip_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             tracking
);

  logic [WIDTH-1:0] g_q;
  logic             v_q;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] delta;
  state_e           state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) g_q <= G;
    end
  end

  greycode_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .g (g_q),
    .b (b_new)
  );

  // Modulo-2^WIDTH difference: 1 is a step up, all-ones is a step down.
  assign delta = b_new - prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      B         <= '0;
      out_valid <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      skip_err  <= 1'b0;
      err_cnt   <= '0;
      tracking  <= 1'b0;
    end else begin
      out_valid <= v_q;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      skip_err  <= 1'b0;
      if (v_q) begin
        B      <= b_new;
        prev_q <= b_new;
        case (state_q)
          IDLE: begin
            state_q  <= TRACK;
            tracking <= 1'b1;
          end
          TRACK: begin
            if (delta == WIDTH'(1)) begin
              step_up <= 1'b1;
            end else if (delta == '1) begin
              step_down <= 1'b1;
            end else if (delta != '0) begin
              skip_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_greycode_to_binary_tracker.sv
// Bench for greycode_to_binary_tracker: directed table, corner sequences and random
// stimulus checked against a sample-history reference model.
module tb_greycode_to_binary_tracker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] G;

  logic [3:0] B;
  logic       out_valid, step_up, step_down, skip_err, tracking;
  logic [7:0] err_cnt;

  logic [3:0] s_B;
  logic       s_out_valid, s_step_up, s_step_down, s_skip_err, s_tracking;
  logic [1:0] s_err_cnt;

  int total = 0;
  int bad   = 0;

  greycode_to_binary_tracker #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .G(G), .in_valid(in_valid), .B(B), .out_valid(out_valid),
    .step_up(step_up), .step_down(step_down), .skip_err(skip_err), .err_cnt(err_cnt),
    .tracking(tracking)
  );

  greycode_to_binary_tracker #(.WIDTH(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .G(G), .in_valid(in_valid), .B(s_B), .out_valid(s_out_valid),
    .step_up(s_step_up), .step_down(s_step_down), .skip_err(s_skip_err),
    .err_cnt(s_err_cnt), .tracking(s_tracking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: last accepted sample, baseline and expected outputs.
  bit m_pend;
  int m_pg, m_prev, m_b, m_err, m_err_sat;
  bit m_trk, e_valid, e_up, e_down, e_skip;
  int n_valid, n_up, n_skip_sat;

  function automatic int to_bin(input int g);
    for (int b = 0; b < 16; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [3:0] g);
    int bn, d;
    rst = r; in_valid = v; G = g;
    @(posedge clk);
    #1;
    e_valid = 0; e_up = 0; e_down = 0; e_skip = 0;
    if (r) begin
      m_pend = 0; m_prev = 0; m_b = 0; m_trk = 0; m_err = 0; m_err_sat = 0;
    end else begin
      if (m_pend) begin
        e_valid = 1;
        bn = to_bin(m_pg);
        if (m_trk) begin
          d = (bn - m_prev + 16) % 16;
          if (d == 1) e_up = 1;
          else if (d == 15) e_down = 1;
          else if (d != 0) begin
            e_skip = 1;
            if (m_err < 255) m_err++;
            if (m_err_sat < 3) m_err_sat++;
          end
        end
        m_trk = 1; m_prev = bn; m_b = bn;
      end
      m_pend = v; m_pg = int'(g);
    end
    chk("out_valid", int'(out_valid), int'(e_valid));
    chk("B", int'(B), m_b);
    chk("step_up", int'(step_up), int'(e_up));
    chk("step_down", int'(step_down), int'(e_down));
    chk("skip_err", int'(skip_err), int'(e_skip));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("tracking", int'(tracking), int'(m_trk));
    chk("sat_err_cnt", int'(s_err_cnt), m_err_sat);
    chk("sat_skip_err", int'(s_skip_err), int'(e_skip));
    n_valid += int'(out_valid);
    n_up += int'(step_up);
    n_skip_sat += int'(s_skip_err);
  endtask

  typedef struct {
    logic r, v; logic [3:0] g;
    logic ev; logic [3:0] eb; logic eu, ed, es; int ee; logic et;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Each row's expectations describe outputs after that row's edge.
    tbl[0] = '{1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'b0011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; G = '0;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("reset_B", int'(B), 0);
    chk("reset_tracking", int'(tracking), 0);

    // Wrap up/down, skip and repeat.
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].g);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_B", i), int'(B), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_up", i), int'(step_up), int'(tbl[i].eu));
      chk($sformatf("tbl%0d_down", i), int'(step_down), int'(tbl[i].ed));
      chk($sformatf("tbl%0d_skip", i), int'(skip_err), int'(tbl[i].es));
      chk($sformatf("tbl%0d_err", i), int'(err_cnt), tbl[i].ee);
      chk($sformatf("tbl%0d_trk", i), int'(tracking), int'(tbl[i].et));
    end

    // Reset right after a sampling edge drops the in-flight sample.
    cycle(0, 1, 4'b0001);
    cycle(1, 1, 4'b0001);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_trk", int'(tracking), 0);
    chk("midrst_B", int'(B), 0);
    chk("midrst_err", int'(err_cnt), 0);
    cycle(0, 1, 4'b0001);
    cycle(0, 0, 0);
    chk("rebase_valid", int'(out_valid), 1);
    chk("rebase_flags", int'({step_up, step_down, skip_err}), 0);
    chk("rebase_B", int'(B), 1);

    // Exhaustive decode, counting upward.
    cycle(1, 0, 0);
    n_valid = 0; n_up = 0;
    for (int b = 0; b < 16; b++) cycle(0, 1, 4'(b ^ (b >> 1)));
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("exh_valid_count", n_valid, 16);
    chk("exh_up_count", n_up, 15);
    chk("exh_err", int'(err_cnt), 0);

    // Saturation of the narrow error counter.
    cycle(1, 0, 0);
    n_skip_sat = 0;
    for (int k = 0; k < 6; k++) cycle(0, 1, (k % 2 == 0) ? 4'b0000 : 4'b0110);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("sat_skip_count", n_skip_sat, 5);
    chk("sat_err_stuck", int'(s_err_cnt), 3);
    chk("wide_err", int'(err_cnt), 5);

    // Gapped input every third cycle.
    cycle(1, 0, 0);
    n_valid = 0; n_up = 0;
    cycle(0, 1, 4'b0000); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 1, 4'b0001); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 1, 4'b0011); cycle(0, 0, 0); cycle(0, 0, 0);
    chk("gap_valid_count", n_valid, 3);
    chk("gap_up_count", n_up, 2);
    chk("gap_B_held", int'(B), 2);

    // Random stimulus, biased towards small steps so up/down paths get exercised.
    for (int n = 0; n < 400; n++) begin
      int cur, nb;
      cur = m_pend ? to_bin(m_pg) : m_b;
      case ($urandom_range(3))
        0: nb = (cur + 1) % 16;
        1: nb = (cur + 15) % 16;
        2: nb = cur;
        default: nb = int'($urandom_range(15));
      endcase
      cycle(($urandom_range(39) == 0), ($urandom_range(2) != 0), 4'(nb ^ (nb >> 1)));
    end
    cycle(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
